frame_formatter_tx: RTL and testbench

- Transmit-side counterpart of the bit-serial frame synchronizer.
- Builds a serial frame: a syncword of configurable length, sent MSB first, followed by a payload of (bitsPerWord+1)*(wordsPerFrame+1) bits pulled from an upstream source.
- Shares the receiver's length conventions, so a loopback of bitOut into the receiver achieves lock.
- Sits between the payload data source and the serial modulator/line driver; all timing is qualified by clkEn.

---
 rtl/frame_formatter_pkg.sv | 21 ++
 rtl/frame_bit_counter.sv | 55 +++++
 rtl/frame_formatter_tx.sv | 187 ++++++++++++++++++
 tb/tb_frame_formatter_tx.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_formatter_pkg.sv
// Shared types and widths for the bit-serial frame formatter (transmit side).
package frame_formatter_pkg;

    localparam int BITCNT_W = 5;
    localparam int WPF_W    = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        SYNC    = 2'b01,
        PAYLOAD = 2'b11
    } state_t;

    // Operations on the bit/word down-counter pair.
    typedef enum logic [1:0] {
        CNT_HOLD      = 2'b00,
        CNT_LOAD      = 2'b01,
        CNT_NEXT_WORD = 2'b10,
        CNT_DEC       = 2'b11
    } cnt_op_t;

endpackage

// File: rtl/frame_bit_counter.sv
// Bit/word down-counter pair shared by the sync and payload phases.
// Flags report when the current bit or word counter has reached zero.
module frame_bit_counter
    import frame_formatter_pkg::*;
#(
    parameter int BIT_W  = BITCNT_W,
    parameter int WORD_W = WPF_W
) (
    input  logic              clk,
    input  logic              reset,
    input  cnt_op_t           op,
    input  logic [BIT_W-1:0]  bit_load,
    input  logic [WORD_W-1:0] word_load,
    output logic [BIT_W-1:0]  bit_cnt,
    output logic              bit_last,
    output logic              word_last
);

    logic [BIT_W-1:0]  bit_cnt_q,  bit_cnt_d;
    logic [WORD_W-1:0] word_cnt_q, word_cnt_d;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        bit_cnt_d  = bit_cnt_q;
        word_cnt_d = word_cnt_q;
        unique case (op)
            CNT_LOAD: begin
                bit_cnt_d  = bit_load;
                word_cnt_d = word_load;
            end
            CNT_NEXT_WORD: begin
                bit_cnt_d  = bit_load;
                word_cnt_d = word_cnt_q - WORD_W'(1);
            end
            CNT_DEC:  bit_cnt_d = bit_cnt_q - BIT_W'(1);
            default:  ;
        endcase
    end

    // NOTE: state flops use non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            bit_cnt_q  <= '0;
            word_cnt_q <= '0;
        end else begin
            bit_cnt_q  <= bit_cnt_d;
            word_cnt_q <= word_cnt_d;
        end
    end

    assign bit_cnt   = bit_cnt_q;
    assign bit_last  = (bit_cnt_q == '0);
    assign word_last = (word_cnt_q == '0);

endmodule

// File: rtl/frame_formatter_tx.sv
// Serial frame builder: MSB-first syncword then a payload pulled from upstream.
// Optional FRAMER_TX_INVERT_EN adds invertOut to complement bitOut for a whole frame.
module frame_formatter_tx
    import frame_formatter_pkg::BITCNT_W;
#(
    parameter int SW_MAX = 32,
    parameter int WPF_W  = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clkEn,
    input  logic                enable,
    input  logic [SW_MAX-1:0]   syncword,
    input  logic [BITCNT_W-1:0] syncwordBits,
    input  logic [BITCNT_W-1:0] bitsPerWord,
    input  logic [WPF_W-1:0]    wordsPerFrame,
    input  logic                payloadBit,
`ifdef FRAMER_TX_INVERT_EN
    input  logic                invertOut,
`endif
    output logic                payloadReq,
    output logic                bitOut,
    output logic                syncActive,
    output logic                frameStart,
    output logic                wordEnd
);

    import frame_formatter_pkg::*;

    state_t              state_q, state_d;
    logic [SW_MAX-1:0]   sh_sync_q, sh_sync_d;
    logic [BITCNT_W-1:0] sh_sync_bits_q, sh_sync_bits_d;
    logic [BITCNT_W-1:0] sh_bpw_q, sh_bpw_d;
    logic [WPF_W-1:0]    sh_wpf_q, sh_wpf_d;
    logic                bit_out_q, bit_out_d;
    logic                sync_active_q, sync_active_d;
    logic                frame_start_q, frame_start_d;
    logic                word_end_q, word_end_d;
    logic                latch_cfg;
    logic                out_inv;

    cnt_op_t             cnt_op;
    logic [BITCNT_W-1:0] cnt_bit_load;
    logic [WPF_W-1:0]    cnt_word_load;
    logic [BITCNT_W-1:0] bit_cnt;
    logic                bit_last;
    logic                word_last;

    frame_bit_counter #(
        .BIT_W  (BITCNT_W),
        .WORD_W (WPF_W)
    ) u_counter (
        .clk       (clk),
        .reset     (reset),
        .op        (cnt_op),
        .bit_load  (cnt_bit_load),
        .word_load (cnt_word_load),
        .bit_cnt   (bit_cnt),
        .bit_last  (bit_last),
        .word_last (word_last)
    );

`ifdef FRAMER_TX_INVERT_EN
    logic inv_q, inv_d;

    always_comb begin
        inv_d = inv_q;
        if (latch_cfg) inv_d = invertOut;
    end

    always_ff @(posedge clk) begin
        if (reset) inv_q <= 1'b0;
        else       inv_q <= inv_d;
    end

    assign out_inv = inv_q;
`else
    assign out_inv = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        bit_out_d     = bit_out_q;
        sync_active_d = sync_active_q;
        frame_start_d = 1'b0;
        word_end_d    = 1'b0;
        latch_cfg     = 1'b0;
        cnt_op        = CNT_HOLD;
        cnt_bit_load  = '0;
        cnt_word_load = '0;

        if (clkEn) begin
            unique case (state_q)
                IDLE: begin
                    bit_out_d     = 1'b0;
                    sync_active_d = 1'b0;
                    if (enable) begin
                        latch_cfg    = 1'b1;
                        cnt_op       = CNT_LOAD;
                        cnt_bit_load = syncwordBits;
                        state_d      = SYNC;
                    end
                end
                SYNC: begin
                    bit_out_d     = sh_sync_q[bit_cnt] ^ out_inv;
                    sync_active_d = 1'b1;
                    frame_start_d = (bit_cnt == sh_sync_bits_q);
                    if (bit_last) begin
                        cnt_op        = CNT_LOAD;
                        cnt_bit_load  = sh_bpw_q;
                        cnt_word_load = sh_wpf_q;
                        state_d       = PAYLOAD;
                    end else begin
                        cnt_op = CNT_DEC;
                    end
                end
                PAYLOAD: begin
                    bit_out_d     = payloadBit ^ out_inv;
                    sync_active_d = 1'b0;
                    if (bit_last) begin
                        word_end_d = 1'b1;
                        if (word_last && enable) begin
                            // Back-to-back frame: next sync bit follows with no gap.
                            latch_cfg    = 1'b1;
                            cnt_op       = CNT_LOAD;
                            cnt_bit_load = syncwordBits;
                            state_d      = SYNC;
                        end else if (word_last) begin
                            state_d = IDLE;
                        end else begin
                            cnt_op       = CNT_NEXT_WORD;
                            cnt_bit_load = sh_bpw_q;
                        end
                    end else begin
                        cnt_op = CNT_DEC;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Shadow config only moves at a frame boundary so mid-frame input changes wait a frame.
    always_comb begin
        sh_sync_d      = sh_sync_q;
        sh_sync_bits_d = sh_sync_bits_q;
        sh_bpw_d       = sh_bpw_q;
        sh_wpf_d       = sh_wpf_q;
        if (latch_cfg) begin
            sh_sync_d      = syncword;
            sh_sync_bits_d = syncwordBits;
            sh_bpw_d       = bitsPerWord;
            sh_wpf_d       = wordsPerFrame;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            sh_sync_q      <= '0;
            sh_sync_bits_q <= '0;
            sh_bpw_q       <= '0;
            sh_wpf_q       <= '0;
            bit_out_q      <= 1'b0;
            sync_active_q  <= 1'b0;
            frame_start_q  <= 1'b0;
            word_end_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            sh_sync_q      <= sh_sync_d;
            sh_sync_bits_q <= sh_sync_bits_d;
            sh_bpw_q       <= sh_bpw_d;
            sh_wpf_q       <= sh_wpf_d;
            bit_out_q      <= bit_out_d;
            sync_active_q  <= sync_active_d;
            frame_start_q  <= frame_start_d;
            word_end_q     <= word_end_d;
        end
    end

    assign payloadReq = (state_q == PAYLOAD) & clkEn;
    assign bitOut     = bit_out_q;
    assign syncActive = sync_active_q;
    assign frameStart = frame_start_q;
    assign wordEnd    = word_end_q;

endmodule

// File: tb/tb_frame_formatter_tx.sv
// Directed self-checking bench for frame_formatter_tx with hand-computed frame images.
// Invert checks are compiled in when FRAMER_TX_INVERT_EN is defined.
module tb_frame_formatter_tx;

    logic        clk = 1'b0;
    logic        reset;
    logic        clkEn;
    logic        enable;
    logic [31:0] syncword;
    logic [4:0]  syncwordBits;
    logic [4:0]  bitsPerWord;
    logic [15:0] wordsPerFrame;
    logic        payloadBit;
    logic        payloadReq;
    logic        bitOut;
    logic        syncActive;
    logic        frameStart;
    logic        wordEnd;
`ifdef FRAMER_TX_INVERT_EN
    logic        invert_out;
    logic        nxt_inv;
`endif

    frame_formatter_tx dut (
        .clk           (clk),
        .reset         (reset),
        .clkEn         (clkEn),
        .enable        (enable),
        .syncword      (syncword),
        .syncwordBits  (syncwordBits),
        .bitsPerWord   (bitsPerWord),
        .wordsPerFrame (wordsPerFrame),
        .payloadBit    (payloadBit),
`ifdef FRAMER_TX_INVERT_EN
        .invertOut     (invert_out),
`endif
        .payloadReq    (payloadReq),
        .bitOut        (bitOut),
        .syncActive    (syncActive),
        .frameStart    (frameStart),
        .wordEnd       (wordEnd)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          en_div   = 1;
    int          div_cnt  = 0;
    logic        s_en, s_req;
    logic [31:0] pay_pat;
    logic [63:0] cap_data, cap_sync, cap_we;
    int          n_req, stable_err;

    logic [31:0] nxt_sw;
    logic [4:0]  nxt_sb, nxt_bpw;
    logic [15:0] nxt_wpf;
    logic        nxt_en;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // One clk: pick clkEn, sample the strobe/request before the edge, then advance the payload source.
    task automatic tick();
        div_cnt = (div_cnt + 1 >= en_div) ? 0 : div_cnt + 1;
        clkEn   = (div_cnt == 0);
        @(negedge clk);
        #1;
        s_en  = clkEn;
        s_req = payloadReq;
        @(posedge clk);
        #1;
        if (s_req) pay_pat = pay_pat << 1;
        payloadBit = pay_pat[31];
    endtask

    task automatic set_nxt(input logic [31:0] sw, input logic [4:0] sb, input logic [4:0] bpw,
                           input logic [15:0] wpf, input logic en);
        nxt_sw = sw; nxt_sb = sb; nxt_bpw = bpw; nxt_wpf = wpf; nxt_en = en;
    endtask

    task automatic apply_nxt();
        syncword = nxt_sw; syncwordBits = nxt_sb; bitsPerWord = nxt_bpw;
        wordsPerFrame = nxt_wpf; enable = nxt_en;
`ifdef FRAMER_TX_INVERT_EN
        invert_out = nxt_inv;
`endif
    endtask

    // Ticks until a frameStart pulse; returns the tick count or -1 when the budget runs out.
    task automatic wait_fs(input int limit, output int clks);
        clks = -1;
        for (int i = 1; i <= limit; i++) begin
            tick();
            if (frameStart) begin
                clks = i;
                return;
            end
        end
    endtask

    // Called on a frameStart sample: records nbits line bits (first bit ends up MSB).
    task automatic grab(input int nbits, input logic [31:0] pat, input int chg_at, output int ticks);
        int   got;
        logic prev;
        pay_pat    = pat;
        payloadBit = pay_pat[31];
        cap_data   = {cap_data[62:0], bitOut};
        cap_sync   = {cap_sync[62:0], syncActive};
        cap_we     = {cap_we[62:0], wordEnd};
        n_req      = 0;
        stable_err = 0;
        ticks      = 0;
        got        = 1;
        prev       = bitOut;
        if (chg_at == 0) apply_nxt();
        while (got < nbits && ticks < 4000) begin
            tick();
            ticks++;
            if (s_req) n_req++;
            if (s_en) begin
                cap_data = {cap_data[62:0], bitOut};
                cap_sync = {cap_sync[62:0], syncActive};
                cap_we   = {cap_we[62:0], wordEnd};
                got++;
                if (got - 1 == chg_at) apply_nxt();
            end else if (bitOut !== prev || frameStart || wordEnd) begin
                stable_err++;
            end
            prev = bitOut;
        end
        check("grab_len", got, nbits);
    endtask

    int t, w;

    initial begin
        reset = 1'b1; enable = 1'b0; clkEn = 1'b1; payloadBit = 1'b0; pay_pat = '0;
        cap_data = '0; cap_sync = '0; cap_we = '0;
        syncword = 32'hFE6B2840; syncwordBits = 5'd31; bitsPerWord = 5'd7; wordsPerFrame = 16'd3;
`ifdef FRAMER_TX_INVERT_EN
        invert_out = 1'b0; nxt_inv = 1'b0;
`endif
        set_nxt(32'hFE6B2840, 5'd31, 5'd7, 16'd3, 1'b1);
        repeat (3) tick();
        check("rst_bitOut", bitOut, 0);
        check("rst_syncActive", syncActive, 0);
        check("rst_frameStart", frameStart, 0);
        check("rst_wordEnd", wordEnd, 0);
        check("rst_payloadReq", payloadReq, 0);

        // Basic frame: FE6B2840 then 32 ones, four words of eight.
        reset = 1'b0; enable = 1'b1;
        wait_fs(100, t);
        check("start_latency", t, 2);
        grab(64, 32'hFFFF_FFFF, -1, t);
        check("basic_sync", cap_data[63:32], 32'hFE6B2840);
        check("basic_payload", cap_data[31:0], 32'hFFFF_FFFF);
        check("basic_syncActive", cap_sync, 64'hFFFF_FFFF_0000_0000);
        check("basic_wordEnd", cap_we, 64'h0000_0000_0101_0101);
        check("basic_req", n_req, 32);
        wait_fs(200, w);
        check("basic_period", t + w, 64);

        // clkEn at one third of clk.
        en_div = 3;
        wait_fs(400, w);
        grab(64, 32'hA5C3_0F96, -1, t);
        check("div3_sync", cap_data[63:32], 32'hFE6B2840);
        check("div3_payload", cap_data[31:0], 32'hA5C3_0F96);
        check("div3_req", n_req, 32);
        check("div3_stable", stable_err, 0);
        check("div3_wordEnd", cap_we, 64'h0000_0000_0101_0101);
        wait_fs(600, w);
        check("div3_period", t + w, 192);

        // wordsPerFrame 3 -> 1 during payload: this frame stays 64, next is 48.
        en_div = 1;
        set_nxt(32'hFE6B2840, 5'd31, 5'd7, 16'd1, 1'b1);
        grab(64, 32'h0F0F_0F0F, 40, t);
        check("cfg_cur_payload", cap_data[31:0], 32'h0F0F_0F0F);
        wait_fs(200, w);
        check("cfg_cur_period", t + w, 64);
        set_nxt(32'h0000_0001, 5'd0, 5'd0, 16'd0, 1'b1);
        grab(48, 32'h3CA5_0000, 10, t);
        check("cfg_next_sync", cap_data[47:16], 32'hFE6B2840);
        check("cfg_next_payload", cap_data[15:0], 16'h3CA5);
        check("cfg_next_wordEnd", cap_we[47:0], 48'h0000_0000_0101);
        wait_fs(200, w);
        check("cfg_next_period", t + w, 48);

        // Degenerate 1-bit sync and 1-bit payload.
        set_nxt(32'hFE6B2840, 5'd31, 5'd7, 16'd3, 1'b1);
        grab(2, 32'h0000_0000, 0, t);
        check("deg_bits", cap_data[1:0], 2'b10);
        check("deg_syncActive", cap_sync[1:0], 2'b10);
        check("deg_wordEnd", cap_we[1:0], 2'b01);
        wait_fs(50, w);
        check("deg_period", t + w, 2);

        // enable dropped at sync bit 10: frame completes, then IDLE.
        set_nxt(32'hFE6B2840, 5'd31, 5'd7, 16'd3, 1'b0);
        grab(64, 32'hFFFF_FFFF, 10, t);
        check("drop_frame", cap_data, 64'hFE6B2840_FFFFFFFF);
        tick();
        check("drop_idle_bitOut", bitOut, 0);
        check("drop_idle_syncActive", syncActive, 0);
        check("drop_idle_req", payloadReq, 0);
        wait_fs(200, w);
        check("drop_no_frameStart", w, -1);

        // Reset during payload word 2.
        enable = 1'b1;
        wait_fs(50, w);
        check("restart_latency", w, 2);
        grab(50, 32'hFFFF_FFFF, -1, t);
        check("pre_reset_bitOut", bitOut, 1);
        reset = 1'b1;
        tick();
        check("mid_rst_bitOut", bitOut, 0);
        check("mid_rst_syncActive", syncActive, 0);
        check("mid_rst_req", payloadReq, 0);
        reset = 1'b0;
        wait_fs(50, w);
        check("post_rst_latency", w, 2);
        set_nxt(32'h00FA_F320, 5'd23, 5'd15, 16'd1, 1'b1);
        grab(64, 32'hC0FF_EE11, 20, t);
        check("post_rst_frame", cap_data, 64'hFE6B2840_C0FFEE11);
        wait_fs(200, w);
        check("post_rst_period", t + w, 64);

        // 24-bit syncword FAF320 with 16-bit words.
`ifdef FRAMER_TX_INVERT_EN
        nxt_inv = 1'b1;
        set_nxt(32'hFE6B2840, 5'd31, 5'd7, 16'd3, 1'b1);
        grab(56, 32'h1234_5678, 30, t);
`else
        grab(56, 32'h1234_5678, -1, t);
`endif
        check("sw24_sync", cap_data[55:32], 24'hFAF320);
        check("sw24_payload", cap_data[31:0], 32'h1234_5678);
        check("sw24_syncActive", cap_sync[55:0], 56'hFF_FFFF_0000_0000);
        check("sw24_wordEnd", cap_we[55:0], 56'h00_0000_0001_0001);
        wait_fs(200, w);
        check("sw24_period", t + w, 56);

`ifdef FRAMER_TX_INVERT_EN
        grab(64, 32'hFFFF_FFFF, -1, t);
        check("inv_frame", cap_data, ~64'hFE6B2840_FFFFFFFF);
        check("inv_syncActive", cap_sync, 64'hFFFF_FFFF_0000_0000);
        check("inv_wordEnd", cap_we, 64'h0000_0000_0101_0101);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
